// File: rtl/layer_compositor_if.sv
// Attribute-table load / commit handshake between the scene loader and layer_compositor.
interface layer_compositor_if #(
   parameter int NUM_SLOTS  = 8,
   parameter int DEPTH_BITS = 4
);
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic                  attr_valid_in;
   logic                  attr_ready_out;
   logic [SLOT_W-1:0]     attr_slot_in;
   logic                  attr_enable_in;
   logic [3:0]            attr_fill_color_in;
   logic [3:0]            attr_edge_color_in;
   logic [DEPTH_BITS-1:0] attr_depth_in;
   logic                  commit_in;
   logic                  pending_out;

   modport master (
      output attr_valid_in, attr_slot_in, attr_enable_in, attr_fill_color_in,
             attr_edge_color_in, attr_depth_in, commit_in,
      input  attr_ready_out, pending_out
   );

   modport slave (
      input  attr_valid_in, attr_slot_in, attr_enable_in, attr_fill_color_in,
             attr_edge_color_in, attr_depth_in, commit_in,
      output attr_ready_out, pending_out
   );
endinterface

// File: rtl/layer_compositor.sv
// Depth-sorted pixel compositor: double-buffered slot attributes feeding a registered min-key tree.
// Define LAYER_COMPOSITOR_HIT_COUNT_EN to add the per-frame non-background pixel counter.
module layer_compositor #(
   parameter int         NUM_SLOTS        = 8,
   parameter int         DEPTH_BITS       = 4,
   parameter int         PIXEL_WIDTH      = 1280,
   parameter int         PIXEL_HEIGHT     = 720,
   parameter logic [3:0] BACKGROUND_COLOR = 4'h1,
   localparam int HC_W  = $clog2(PIXEL_WIDTH),
   localparam int VC_W  = $clog2(PIXEL_HEIGHT),
   localparam int CNT_W = $clog2(PIXEL_WIDTH*PIXEL_HEIGHT+1)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [HC_W-1:0]      hcount_in,
   input  logic [VC_W-1:0]      vcount_in,
   input  logic                 pixel_valid_in,
   input  logic [NUM_SLOTS-1:0] edge_hits_in,
   input  logic [NUM_SLOTS-1:0] fill_hits_in,
   layer_compositor_if.slave    attr,
   output logic [3:0]           color_idx_out,
   output logic [HC_W-1:0]      hcount_out,
   output logic [VC_W-1:0]      vcount_out,
   output logic                 pixel_valid_out,
   output logic [CNT_W-1:0]     hit_count_out
);
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int LVL    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 0;
   localparam int P      = 1 << LVL;
   localparam int KEY_W  = DEPTH_BITS + SLOT_W;
   localparam int L      = LVL + 2;

   typedef struct packed {
      logic                  enable;
      logic [3:0]            fill_color;
      logic [3:0]            edge_color;
      logic [DEPTH_BITS-1:0] depth;
   } attr_t;

   typedef struct packed {
      logic             hit;
      logic [3:0]       color;
      logic [KEY_W-1:0] key;
   } node_t;

   attr_t active_q [NUM_SLOTS];
   attr_t shadow_q [NUM_SLOTS];
   attr_t eff      [NUM_SLOTS];
   logic  pending_q;
   logic  frame_start, swap, attr_wr;

   node_t leaf   [P];
   node_t tree_q [LVL+1][P];

   logic [L-1:0]           vld_pipe_q;
   logic [L-1:0][HC_W-1:0] hc_pipe_q;
   logic [L-1:0][VC_W-1:0] vc_pipe_q;
   logic [3:0]             color_q;
   logic                   hit_q;

   assign frame_start         = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
   assign swap                = frame_start && pending_q;
   assign attr_wr             = attr.attr_valid_in && !pending_q;
   assign attr.attr_ready_out = !pending_q;
   assign attr.pending_out    = pending_q;

   function automatic node_t pick(node_t a, node_t b);
      return (a.hit && (!b.hit || a.key < b.key)) ? a : b;
   endfunction

   // The frame-start pixel already sees the table being swapped in on this edge.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) eff[i] = swap ? shadow_q[i] : active_q[i];
   end

   always_comb begin
      for (int i = 0; i < P; i++) leaf[i] = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         leaf[i].hit   = eff[i].enable && (edge_hits_in[i] || fill_hits_in[i]);
         leaf[i].color = edge_hits_in[i] ? eff[i].edge_color : eff[i].fill_color;
         leaf[i].key   = {eff[i].depth, SLOT_W'(i)};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            active_q[i] <= '0;
            shadow_q[i] <= '0;
         end
         pending_q <= 1'b0;
      end else begin
         if (attr_wr && (int'(attr.attr_slot_in) < NUM_SLOTS))
            shadow_q[attr.attr_slot_in] <= {attr.attr_enable_in, attr.attr_fill_color_in,
                                            attr.attr_edge_color_in, attr.attr_depth_in};
         if (swap) begin
            for (int i = 0; i < NUM_SLOTS; i++) active_q[i] <= shadow_q[i];
            pending_q <= 1'b0;
         end
         if (attr.commit_in && !pending_q) pending_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int l = 0; l <= LVL; l++)
            for (int i = 0; i < P; i++) tree_q[l][i] <= '0;
         vld_pipe_q <= '0;
         hc_pipe_q  <= '0;
         vc_pipe_q  <= '0;
         color_q    <= BACKGROUND_COLOR;
         hit_q      <= 1'b0;
      end else begin
         for (int i = 0; i < P; i++) tree_q[0][i] <= leaf[i];
         for (int l = 1; l <= LVL; l++)
            for (int i = 0; i < (P >> l); i++)
               tree_q[l][i] <= pick(tree_q[l-1][2*i], tree_q[l-1][2*i+1]);
         vld_pipe_q <= {vld_pipe_q[L-2:0], pixel_valid_in};
         hc_pipe_q  <= {hc_pipe_q[L-2:0], hcount_in};
         vc_pipe_q  <= {vc_pipe_q[L-2:0], vcount_in};
         hit_q      <= vld_pipe_q[L-2] && tree_q[LVL][0].hit;
         color_q    <= (vld_pipe_q[L-2] && tree_q[LVL][0].hit) ? tree_q[LVL][0].color
                                                               : BACKGROUND_COLOR;
      end
   end

   assign color_idx_out   = color_q;
   assign pixel_valid_out = vld_pipe_q[L-1];
   assign hcount_out      = hc_pipe_q[L-1];
   assign vcount_out      = vc_pipe_q[L-1];

`ifdef LAYER_COMPOSITOR_HIT_COUNT_EN
   logic [CNT_W-1:0] cnt_q, hit_cnt_q;
   logic             out_frame_start;

   assign out_frame_start = pixel_valid_out && (hcount_out == '0) && (vcount_out == '0);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q     <= '0;
         hit_cnt_q <= '0;
      end else if (out_frame_start) begin
         hit_cnt_q <= cnt_q;
         cnt_q     <= CNT_W'(hit_q);
      end else if (hit_q && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hit_count_out = hit_cnt_q;
`else
   assign hit_count_out = '0;
`endif
endmodule

// File: tb/tb_layer_compositor.sv
// Randomized self-checking bench for layer_compositor against a slot-scan reference model.
module tb_layer_compositor;
   localparam int         NS = 8;
   localparam int         L  = 5;
   localparam logic [3:0] BG = 4'h1;

   typedef struct packed {
      logic       v;
      logic [3:0] h;
      logic [2:0] y;
      logic [3:0] c;
   } exp_t;

   typedef struct {
      logic       en;
      logic [3:0] fc;
      logic [3:0] ec;
      logic [3:0] dep;
   } slot_t;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic [3:0]    hcount_in;
   logic [2:0]    vcount_in;
   logic          pixel_valid_in;
   logic [NS-1:0] edge_hits_in, fill_hits_in;
   logic [3:0]    color_idx_out;
   logic [3:0]    hcount_out;
   logic [2:0]    vcount_out;
   logic          pixel_valid_out;
   logic [7:0]    hit_count_out;

   layer_compositor_if #(.NUM_SLOTS(NS), .DEPTH_BITS(4)) aif ();

   layer_compositor #(
      .NUM_SLOTS(NS), .DEPTH_BITS(4), .PIXEL_WIDTH(16), .PIXEL_HEIGHT(8), .BACKGROUND_COLOR(BG)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .pixel_valid_in(pixel_valid_in), .edge_hits_in(edge_hits_in), .fill_hits_in(fill_hits_in),
      .attr(aif), .color_idx_out(color_idx_out), .hcount_out(hcount_out),
      .vcount_out(vcount_out), .pixel_valid_out(pixel_valid_out), .hit_count_out(hit_count_out)
   );

   always #5 clk_in = ~clk_in;

   wire exp_t obs = {pixel_valid_out, hcount_out, vcount_out, color_idx_out};

   slot_t m_act [NS];
   slot_t m_shd [NS];
   logic  m_pending;
   exp_t  exp_q [$];
   exp_t  cur;
   logic  have_cur;
   int    n_chk = 0, n_pass = 0;

   // Nearest enabled hit by linear scan; strict '<' keeps the lower slot on depth ties.
   function automatic logic [3:0] ref_color(logic v, logic [NS-1:0] e, logic [NS-1:0] f);
      int best = -1;
      for (int s = 0; s < NS; s++)
         if (m_act[s].en && (e[s] || f[s]))
            if (best < 0 || m_act[s].dep < m_act[best].dep) best = s;
      if (!v || best < 0) return BG;
      return e[best] ? m_act[best].ec : m_act[best].fc;
   endfunction

   task automatic reset_model;
      for (int s = 0; s < NS; s++) begin
         m_act[s] = '{1'b0, 4'h0, 4'h0, 4'h0};
         m_shd[s] = '{1'b0, 4'h0, 4'h0, 4'h0};
      end
      m_pending = 1'b0;
      exp_q.delete();
      for (int i = 0; i < L-1; i++) exp_q.push_back('{1'b0, 4'd0, 3'd0, BG});
   endtask

   task automatic load_attr(input int slot, input logic en, input logic [3:0] fc,
                            input logic [3:0] ec, input logic [3:0] dep, input logic cm);
      aif.attr_valid_in      = 1'b1;
      aif.attr_slot_in       = 3'(slot);
      aif.attr_enable_in     = en;
      aif.attr_fill_color_in = fc;
      aif.attr_edge_color_in = ec;
      aif.attr_depth_in      = dep;
      aif.commit_in          = cm;
   endtask

   task automatic drive_pix(input logic v, input logic [3:0] h, input logic [2:0] y,
                            input logic [NS-1:0] e, input logic [NS-1:0] f);
      logic pend_pre;
      exp_t x;
      pixel_valid_in = v; hcount_in = h; vcount_in = y;
      edge_hits_in   = e; fill_hits_in = f;
      pend_pre = m_pending;
      if (v && h == 0 && y == 0 && pend_pre) begin
         m_act     = m_shd;
         m_pending = 1'b0;
      end
      if (aif.attr_valid_in && !pend_pre)
         m_shd[aif.attr_slot_in] = '{aif.attr_enable_in, aif.attr_fill_color_in,
                                     aif.attr_edge_color_in, aif.attr_depth_in};
      if (aif.commit_in && !pend_pre) m_pending = 1'b1;
      x = '{v, h, y, ref_color(v, e, f)};
      exp_q.push_back(x);
      @(posedge clk_in); #1;
      aif.attr_valid_in = 1'b0;
      aif.commit_in     = 1'b0;
      have_cur = (exp_q.size() == L);
      if (have_cur) cur = exp_q.pop_front();
   endtask

   task automatic test_reset;
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      n_chk++;
      if (obs !== exp_t'({1'b0, 4'd0, 3'd0, BG}))
         $display("FAIL reset_out: got %h want %h", obs, {1'b0, 4'd0, 3'd0, BG});
      else n_pass++;
      n_chk++;
      if ({aif.pending_out, aif.attr_ready_out} !== 2'b01)
         $display("FAIL reset_hs: got pend/rdy %b%b want 01", aif.pending_out, aif.attr_ready_out);
      else n_pass++;
      n_chk++;
      if (hit_count_out !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", hit_count_out);
      else n_pass++;
      @(negedge clk_in);
      rst_in = 1'b1;
      reset_model();
   endtask

   task automatic test_background;
      for (int y = 0; y < 2; y++)
         for (int h = 0; h < 16; h++) begin
            drive_pix(1'b1, 4'(h), 3'(y), 8'hFF, 8'hFF);
            if (have_cur) begin
               n_chk++;
               if (obs !== cur) $display("FAIL background: got %h want %h", obs, cur);
               else n_pass++;
            end
         end
   endtask

   task automatic test_depth_tie;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            load_attr(2, 1'b1, 4'h3, 4'h0, 4'd5, 1'b0); drive_pix(0, 0, 0, 0, 0);
            load_attr(6, 1'b1, 4'hA, 4'h0, 4'd5, 1'b1); drive_pix(0, 0, 0, 0, 0);
         end else begin
            load_attr(6, 1'b1, 4'hA, 4'h0, 4'd2, 1'b1); drive_pix(0, 0, 0, 0, 0);
         end
         for (int h = 0; h < 8; h++) begin
            drive_pix(1'b1, 4'(h), 3'd0, 8'h00, 8'h44);
            if (have_cur) begin
               n_chk++;
               if (obs !== cur) $display("FAIL depth_tie: got %h want %h", obs, cur);
               else n_pass++;
            end
         end
         n_chk++;
         if (color_idx_out !== ((pass == 0) ? 4'h3 : 4'hA))
            $display("FAIL depth_tie_final%0d: got %h want %h", pass, color_idx_out,
                     (pass == 0) ? 4'h3 : 4'hA);
         else n_pass++;
      end
   endtask

   task automatic test_edge_priority;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            load_attr(2, 1'b0, 4'h3, 4'h0, 4'd5, 1'b1); drive_pix(0, 0, 0, 0, 0);
         end
         for (int h = 0; h < 8; h++) begin
            drive_pix(1'b1, 4'(h), 3'd0, 8'h04, 8'h04);
            if (have_cur) begin
               n_chk++;
               if (obs !== cur) $display("FAIL edge_prio: got %h want %h", obs, cur);
               else n_pass++;
            end
         end
         n_chk++;
         if (color_idx_out !== ((pass == 0) ? 4'h0 : BG))
            $display("FAIL edge_prio_final%0d: got %h want %h", pass, color_idx_out,
                     (pass == 0) ? 4'h0 : BG);
         else n_pass++;
      end
   endtask

   task automatic test_commit_midframe;
      load_attr(2, 1'b1, 4'h3, 4'h0, 4'd5, 1'b1); drive_pix(0, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         if (i == 2) load_attr(2, 1'b1, 4'h7, 4'h0, 4'd5, 1'b1);
         if (i == 6) load_attr(2, 1'b1, 4'h9, 4'h0, 4'd5, 1'b1);
         if (i == 1 || i == 8) drive_pix(1'b1, 4'd0, 3'd0, 8'h00, 8'h04);
         else drive_pix(1'b1, 4'(i + 1), 3'd2, 8'h00, 8'h04);
         if (have_cur) begin
            n_chk++;
            if (obs !== cur) $display("FAIL commit_mid: got %h want %h", obs, cur);
            else n_pass++;
         end
         if (i == 2 || i == 6 || i == 8) begin
            n_chk++;
            if ({aif.pending_out, aif.attr_ready_out} !== ((i == 8) ? 2'b01 : 2'b10))
               $display("FAIL commit_hs%0d: got pend/rdy %b%b want %b", i, aif.pending_out,
                        aif.attr_ready_out, (i == 8) ? 2'b01 : 2'b10);
            else n_pass++;
         end
      end
      n_chk++;
      if (color_idx_out !== 4'h7) $display("FAIL commit_final: got %h want 7", color_idx_out);
      else n_pass++;
   endtask

   task automatic test_random;
      logic [NS-1:0] e, f;
      logic          v;
      logic [3:0]    h;
      logic [2:0]    y;
      for (int s = 0; s < NS; s++) begin
         load_attr(s, $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                   4'($urandom_range(0, 3)), s == NS-1);
         drive_pix(0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0)
            load_attr($urandom_range(0, NS-1), $urandom_range(0, 3) != 0, 4'($urandom),
                      4'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
         v = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 9) == 0) begin h = 4'd0; y = 3'd0; end
         else begin h = 4'($urandom); y = 3'($urandom); end
         e = 8'($urandom) & 8'($urandom) & 8'($urandom);
         f = 8'($urandom) & 8'($urandom);
         drive_pix(v, h, y, e, f);
         if (have_cur) begin
            n_chk++;
            if (obs !== cur) $display("FAIL random[%0d]: got %h want %h", i, obs, cur);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_midframe;
      load_attr(3, 1'b1, 4'hC, 4'hD, 4'd0, 1'b1); drive_pix(0, 0, 0, 0, 0);
      for (int h = 4; h < 8; h++) drive_pix(1'b1, 4'(h), 3'd3, 8'h00, 8'hFF);
      #2 rst_in = 1'b0;
      #1;
      n_chk++;
      if (obs !== exp_t'({1'b0, 4'd0, 3'd0, BG}))
         $display("FAIL rst_mid_out: got %h want %h", obs, {1'b0, 4'd0, 3'd0, BG});
      else n_pass++;
      n_chk++;
      if ({aif.pending_out, aif.attr_ready_out} !== 2'b01)
         $display("FAIL rst_mid_hs: got pend/rdy %b%b want 01", aif.pending_out, aif.attr_ready_out);
      else n_pass++;
      #3 rst_in = 1'b1;
      reset_model();
      for (int h = 0; h < 8; h++) begin
         drive_pix(1'b1, 4'(h), 3'd0, 8'hFF, 8'hFF);
         if (have_cur) begin
            n_chk++;
            if (obs !== cur) $display("FAIL rst_mid_frame: got %h want %h", obs, cur);
            else n_pass++;
         end
      end
      n_chk++;
      if ({color_idx_out, aif.pending_out} !== {BG, 1'b0})
         $display("FAIL rst_mid_final: got c=%h pend=%b want c=%h pend=0", color_idx_out,
                  aif.pending_out, BG);
      else n_pass++;
   endtask

   task automatic test_hit_count;
      logic [7:0] want;
`ifdef LAYER_COMPOSITOR_HIT_COUNT_EN
      want = 8'd16;
`else
      want = 8'd0;
`endif
      load_attr(0, 1'b1, 4'h5, 4'h6, 4'd1, 1'b1); drive_pix(0, 0, 0, 0, 0);
      drive_pix(1'b1, 4'd0, 3'd0, 8'h00, 8'h00);
      for (int y = 1; y < 5; y++)
         for (int h = 1; h < 5; h++) begin
            drive_pix(1'b1, 4'(h), 3'(y), 8'h00, 8'h01);
            if (have_cur) begin
               n_chk++;
               if (obs !== cur) $display("FAIL hitcnt_px: got %h want %h", obs, cur);
               else n_pass++;
            end
         end
      drive_pix(1'b1, 4'd0, 3'd0, 8'h00, 8'h00);
      for (int i = 0; i < L + 2; i++) drive_pix(0, 0, 0, 0, 0);
      n_chk++;
      if (hit_count_out !== want) $display("FAIL hit_count: got %0d want %0d", hit_count_out, want);
      else n_pass++;
   endtask

   initial begin
      rst_in = 1'b0; pixel_valid_in = 1'b0; hcount_in = '0; vcount_in = '0;
      edge_hits_in = '0; fill_hits_in = '0;
      aif.attr_valid_in = 1'b0; aif.attr_slot_in = '0; aif.attr_enable_in = 1'b0;
      aif.attr_fill_color_in = '0; aif.attr_edge_color_in = '0; aif.attr_depth_in = '0;
      aif.commit_in = 1'b0;
      have_cur = 1'b0; cur = '0;
      reset_model();
      test_reset();
      test_background();
      test_depth_tie();
      test_edge_priority();
      test_commit_midframe();
      test_random();
      test_reset_midframe();
      test_hit_count();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
